// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//
// Bundles every signal between the control sequencer and the datapath / ring
// counter, apart from the clock and the reset.
//
//   master : the control sequencer.
//            Inputs  : t_state, bus_in, alu_carry, alu_zero.
//            Outputs : all control strobes, extended_fetch, ring_enable,
//                      halted, ir_operand (and illegal_op when trapping).
//   slave  : the datapath / ring-counter side (mirror image of master).
//
// Signals:
//   t_state        one-hot T-state (T0..T9) from the ring counter
//   bus_in         RAM data; the instruction byte is presented at T2
//   alu_carry      ALU carry-out
//   alu_zero       ALU result == 0
//   pc_count       PC increment
//   pc_load        PC load from bus (jump)
//   pc_out         PC drives bus
//   mar_in         MAR loads from bus
//   ram_out        RAM drives bus
//   ram_in         RAM write
//   ir_out         IR immediate nibble drives bus
//   a_in/a_out     register A load / drive
//   b_in           register B load
//   alu_out        ALU drives bus
//   alu_sub        ALU subtract select
//   out_in         output register load
//   flags_in       flag capture strobe
//   extended_fetch ring counter must run T6..T9 for this instruction
//   ring_enable    ring counter enable (low once halted)
//   halted         HLT executed (sticky)
//   ir_operand     IR[3:0]
//   illegal_op     undefined opcode trapped (only with SEQ_ILLEGAL_TRAP_EN)
//
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN adds the illegal_op signal.
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
);
    logic [9:0]             t_state;
    logic [DATA_W-1:0]      bus_in;
    logic                   alu_carry;
    logic                   alu_zero;

    logic                   pc_count;
    logic                   pc_load;
    logic                   pc_out;
    logic                   mar_in;
    logic                   ram_out;
    logic                   ram_in;
    logic                   ir_out;
    logic                   a_in;
    logic                   a_out;
    logic                   b_in;
    logic                   alu_out;
    logic                   alu_sub;
    logic                   out_in;
    logic                   flags_in;
    logic                   extended_fetch;
    logic                   ring_enable;
    logic                   halted;
    logic [DATA_W-OP_W-1:0] ir_operand;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic                   illegal_op;
`endif

    modport master (
        input  t_state, bus_in, alu_carry, alu_zero,
`ifdef SEQ_ILLEGAL_TRAP_EN
        output illegal_op,
`endif
        output pc_count, pc_load, pc_out, mar_in, ram_out, ram_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, out_in, flags_in,
               extended_fetch, ring_enable, halted, ir_operand
    );

    modport slave (
        output t_state, bus_in, alu_carry, alu_zero,
`ifdef SEQ_ILLEGAL_TRAP_EN
        input  illegal_op,
`endif
        input  pc_count, pc_load, pc_out, mar_in, ram_out, ram_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, out_in, flags_in,
               extended_fetch, ring_enable, halted, ir_operand
    );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Control unit of the 8-bit accumulator machine. Latches the instruction byte
// into the IR at T2, decodes it against the one-hot T-state from the external
// 10-state ring counter and produces the per-state control word. Also holds
// the carry/zero flags, the halt latch and the registered extended_fetch
// request that tells the ring counter to run the T6..T9 window.
//
// Ports:
//   clk    in   system clock, rising edge
//   clear  in   asynchronous active-high reset
//   ctl    control_sequencer_if.master (see the interface file for the list)
//
// Parameters:
//   DATA_W  bus / instruction width (only 8 supported)
//   OP_W    opcode width; IR[7:4] = opcode, IR[3:0] = immediate nibble
//
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN
//   defined     : opcodes 0x9..0xD halt the machine at the T3 edge and set the
//                 sticky illegal_op output.
//   not defined : opcodes 0x9..0xD execute as NOP, no illegal_op port.
//
// Opcode map: NOP 0x0, LDA 0x1, ADD 0x2, SUB 0x3, STA 0x4, LDI 0x5, JMP 0x6,
//             JC 0x7, JZ 0x8, OUT 0xE, HLT 0xF. NOP needs no decode: it is
//             simply the absence of every other match.
//
// Structure: there is no private state machine (sequencing lives in the ring
// counter), but the block is written as the usual three processes: register
// process, next-state combinational process, output combinational process.
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic                clk,
    input  logic                clear,
    control_sequencer_if.master ctl
);

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;
`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam logic [OP_W-1:0] OP_ILL_LO = 4'h9;
    localparam logic [OP_W-1:0] OP_ILL_HI = 4'hD;
`endif

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] ir_reg,      ir_next;
    logic              ext_reg,     ext_next;
    logic              carry_reg,   carry_next;
    logic              zero_reg,    zero_next;
    logic              halted_reg,  halted_next;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic              illegal_reg, illegal_next;
`endif

    // ---------------------------------------------------------------------
    // One-hot qualification of t_state.
    // seen[i] : some bit in t_state[i:0] is set
    // dup[i]  : two or more bits in t_state[i:0] are set
    // ---------------------------------------------------------------------
    logic [9:0] t;
    logic [9:0] seen;
    logic [9:0] dup;
    logic       t_valid;

    assign t       = ctl.t_state;
    assign seen[0] = t[0];
    assign dup[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 10; gi++) begin : g_onehot
            assign seen[gi] = seen[gi-1] | t[gi];
            assign dup[gi]  = dup[gi-1] | (seen[gi-1] & t[gi]);
        end
    endgenerate

    assign t_valid = seen[9] & ~dup[9];

    // Everything (strobes and register updates) is gated by this. clear is
    // included so that no write strobe survives while reset is asserted, even
    // in the instant before the IR has visibly returned to NOP.
    logic active;
    assign active = t_valid & ~halted_reg & ~clear;

    // ---------------------------------------------------------------------
    // Decode of the latched instruction
    // ---------------------------------------------------------------------
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] new_opcode;
    logic            is_mem_ref;   // LDA/ADD/SUB/STA: operand address fetched at T5
    logic            is_jump;      // JMP/JC/JZ: operand is the jump target
    logic            is_alu;       // ADD/SUB
    logic            jump_taken;
    logic            new_is_ext;

    assign opcode     = ir_reg[DATA_W-1 -: OP_W];
    assign new_opcode = ctl.bus_in[DATA_W-1 -: OP_W];

    assign is_alu     = (opcode == OP_ADD) | (opcode == OP_SUB);
    assign is_mem_ref = (opcode == OP_LDA) | is_alu | (opcode == OP_STA);
    assign is_jump    = (opcode == OP_JMP) | (opcode == OP_JC) | (opcode == OP_JZ);
    assign jump_taken = (opcode == OP_JMP)
                      | ((opcode == OP_JC) & carry_reg)
                      | ((opcode == OP_JZ) & zero_reg);

    // Only memory-reference instructions need the T6..T9 window.
    assign new_is_ext = (new_opcode == OP_LDA) | (new_opcode == OP_ADD)
                      | (new_opcode == OP_SUB) | (new_opcode == OP_STA);

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic is_illegal;
    assign is_illegal = (opcode >= OP_ILL_LO) & (opcode <= OP_ILL_HI);
`endif

    // ---------------------------------------------------------------------
    // Output process: control word
    // ---------------------------------------------------------------------
    logic pc_count, pc_load, pc_out, mar_in, ram_out, ram_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, out_in, flags_in;

    always_comb begin
        pc_count = 1'b0;
        pc_load  = 1'b0;
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_in   = 1'b0;
        flags_in = 1'b0;

        if (active) begin
            // Fetch, common to all opcodes. T1 is the RAM read-latency slot.
            if (t[0]) begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end
            if (t[2]) begin
                ram_out  = 1'b1;
                pc_count = 1'b1;
            end

            // T3: operand-address fetch or single-byte execution.
            if (t[3]) begin
                if (is_mem_ref | is_jump) begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                if (opcode == OP_LDI) begin
                    ir_out = 1'b1;
                    a_in   = 1'b1;
                end
                if (opcode == OP_OUT) begin
                    a_out  = 1'b1;
                    out_in = 1'b1;
                end
            end

            // T5: operand byte is on the bus (T4 was the read-latency slot).
            if (t[5]) begin
                if (is_mem_ref) begin
                    // Operand is a data address: move it into the MAR.
                    ram_out  = 1'b1;
                    mar_in   = 1'b1;
                    pc_count = 1'b1;
                end else if (is_jump) begin
                    if (jump_taken) begin
                        ram_out = 1'b1;
                        pc_load = 1'b1;
                    end else begin
                        // Not taken: step over the operand byte.
                        pc_count = 1'b1;
                    end
                end
            end

            // T7: data access (T6 was the read-latency slot).
            if (t[7]) begin
                if (opcode == OP_LDA) begin
                    ram_out = 1'b1;
                    a_in    = 1'b1;
                end
                if (opcode == OP_STA) begin
                    a_out  = 1'b1;
                    ram_in = 1'b1;
                end
                if (is_alu) begin
                    ram_out = 1'b1;
                    b_in    = 1'b1;
                end
            end

            if (t[8] && is_alu) begin
                alu_out  = 1'b1;
                a_in     = 1'b1;
                flags_in = 1'b1;
                alu_sub  = (opcode == OP_SUB);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state process
    // ---------------------------------------------------------------------
    always_comb begin
        ir_next      = ir_reg;
        ext_next     = ext_reg;
        carry_next   = carry_reg;
        zero_next    = zero_reg;
        halted_next  = halted_reg;
`ifdef SEQ_ILLEGAL_TRAP_EN
        illegal_next = illegal_reg;
`endif

        if (active) begin
            if (t[2]) begin
                ir_next  = ctl.bus_in;
                // Held until the next T2 edge, so it is stable at T5 when the
                // ring counter decides whether to continue into T6.
                ext_next = new_is_ext;
            end
            if (t[3] && (opcode == OP_HLT)) begin
                halted_next = 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (t[3] && is_illegal) begin
                halted_next  = 1'b1;
                illegal_next = 1'b1;
            end
`endif
        end

        // flags_in is already qualified by active.
        if (flags_in) begin
            carry_next = ctl.alu_carry;
            zero_next  = ctl.alu_zero;
        end
    end

    // ---------------------------------------------------------------------
    // Register process
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ir_reg      <= '0;
            ext_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b0;
            halted_reg  <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            ir_reg      <= ir_next;
            ext_reg     <= ext_next;
            carry_reg   <= carry_next;
            zero_reg    <= zero_next;
            halted_reg  <= halted_next;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_reg <= illegal_next;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ctl.pc_count       = pc_count;
    assign ctl.pc_load        = pc_load;
    assign ctl.pc_out         = pc_out;
    assign ctl.mar_in         = mar_in;
    assign ctl.ram_out        = ram_out;
    assign ctl.ram_in         = ram_in;
    assign ctl.ir_out         = ir_out;
    assign ctl.a_in           = a_in;
    assign ctl.a_out          = a_out;
    assign ctl.b_in           = b_in;
    assign ctl.alu_out        = alu_out;
    assign ctl.alu_sub        = alu_sub;
    assign ctl.out_in         = out_in;
    assign ctl.flags_in       = flags_in;
    assign ctl.extended_fetch = ext_reg;
    assign ctl.ring_enable    = ~halted_reg;
    assign ctl.halted         = halted_reg;
    assign ctl.ir_operand     = ir_reg[DATA_W-OP_W-1:0];
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign ctl.illegal_op     = illegal_reg;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Drives t_state / bus_in / ALU flags directly (standing in for the ring
// counter and datapath) and compares the control word, extended_fetch,
// ir_operand and halt outputs against hand-computed expectations: a table of
// per-T-state vectors for whole instructions, then hand-written sequences for
// reset, non-one-hot T-states, async clear mid-STA, undefined opcodes and HLT.
// Inputs change on the falling edge; strobes are sampled 1 ns later and
// registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam logic [9:0] T0 = 10'h001, T1 = 10'h002, T2 = 10'h004, T3 = 10'h008,
                           T4 = 10'h010, T5 = 10'h020, T6 = 10'h040, T7 = 10'h080,
                           T8 = 10'h100, T9 = 10'h200;

    // Strobe vector bit masks, packed in the order of strobes() below.
    localparam logic [13:0] K_PC_COUNT = 14'h2000, K_PC_LOAD = 14'h1000,
                            K_PC_OUT   = 14'h0800, K_MAR_IN  = 14'h0400,
                            K_RAM_OUT  = 14'h0200, K_RAM_IN  = 14'h0100,
                            K_IR_OUT   = 14'h0080, K_A_IN    = 14'h0040,
                            K_A_OUT    = 14'h0020, K_B_IN    = 14'h0010,
                            K_ALU_OUT  = 14'h0008, K_ALU_SUB = 14'h0004,
                            K_OUT_IN   = 14'h0002, K_FLAGS   = 14'h0001;
    localparam logic [13:0] K_NONE = 14'h0000;

    logic clk;
    logic clear;

    control_sequencer_if ctl ();

    control_sequencer dut (
        .clk   (clk),
        .clear (clear),
        .ctl   (ctl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [13:0] strobes();
        return {ctl.pc_count, ctl.pc_load, ctl.pc_out, ctl.mar_in, ctl.ram_out,
                ctl.ram_in, ctl.ir_out, ctl.a_in, ctl.a_out, ctl.b_in,
                ctl.alu_out, ctl.alu_sub, ctl.out_in, ctl.flags_in};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic [9:0]  t;
        logic [7:0]  bus;
        logic        c;
        logic        z;
        logic [13:0] strb;   // expected strobes during this state
        logic        ext;    // expected extended_fetch after the edge
        logic [3:0]  opnd;   // expected ir_operand after the edge
    } vec_t;

    vec_t vecs[$];
    logic       b_ext;
    logic [3:0] b_opnd;

    // ALU flag inputs default to 1/1 so any capture outside a flags_in state
    // would corrupt the flags and show up in a later conditional jump.
    function automatic void row(input logic [9:0] t, input logic [13:0] s,
                                input logic c = 1'b1, input logic z = 1'b1);
        vec_t v;
        v.t    = t;
        v.bus  = 8'hFF;
        v.c    = c;
        v.z    = z;
        v.strb = s;
        v.ext  = b_ext;
        v.opnd = b_opnd;
        vecs.push_back(v);
    endfunction

    // T0..T2 of an instruction; ext and operand are supplied by hand.
    function automatic void fetch(input logic [7:0] b, input logic ext);
        vec_t v;
        row(T0, K_PC_OUT | K_MAR_IN);
        row(T1, K_NONE);
        b_ext  = ext;
        b_opnd = b[3:0];
        v.t    = T2;
        v.bus  = b;
        v.c    = 1'b1;
        v.z    = 1'b1;
        v.strb = K_RAM_OUT | K_PC_COUNT;
        v.ext  = ext;
        v.opnd = b[3:0];
        vecs.push_back(v);
    endfunction

    // Apply one T-state: drive on the falling edge, return strobes sampled
    // before the rising edge, then step 1 ns past the rising edge.
    task automatic apply(input logic [9:0] t, input logic [7:0] bus,
                         input logic c, input logic z, output logic [13:0] s);
        @(negedge clk);
        ctl.t_state   = t;
        ctl.bus_in    = bus;
        ctl.alu_carry = c;
        ctl.alu_zero  = z;
        #1;
        s = strobes();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [9:0] t, input logic [7:0] bus,
                        input logic [13:0] exp);
        logic [13:0] s;
        apply(t, bus, 1'b1, 1'b1, s);
        check(name, {2'b00, s}, {2'b00, exp});
        $display("step %s t=%h bus=%h strobes=%h", name, t, bus, s);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        logic [13:0] s;

        clear         = 1'b1;
        ctl.t_state   = T0;
        ctl.bus_in    = 8'h00;
        ctl.alu_carry = 1'b0;
        ctl.alu_zero  = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("reset strobes",     {2'b00, strobes()},        16'h0000);
        check("reset ext",         {15'd0, ctl.extended_fetch}, 16'h0000);
        check("reset halted",      {15'd0, ctl.halted},       16'h0000);
        check("reset ring_enable", {15'd0, ctl.ring_enable},  16'h0001);
        check("reset ir_operand",  {12'd0, ctl.ir_operand},   16'h0000);
        @(negedge clk);
        clear = 1'b0;

        // ---------------- table of whole instructions ----------------
        b_ext  = 1'b0;
        b_opnd = 4'h0;

        fetch(8'h5A, 1'b0);                      // LDI 0xA
        row(T3, K_IR_OUT | K_A_IN);
        row(T4, K_NONE);
        row(T5, K_NONE);

        fetch(8'h70, 1'b0);                      // JC, carry=0 after reset
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_PC_COUNT);

        fetch(8'h20, 1'b1);                      // ADD: carry<=1 zero<=0
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_MAR_IN | K_PC_COUNT);
        row(T6, K_NONE);
        row(T7, K_RAM_OUT | K_B_IN);
        row(T8, K_ALU_OUT | K_A_IN | K_FLAGS, 1'b1, 1'b0);
        row(T9, K_NONE);

        fetch(8'h73, 1'b0);                      // JC, carry=1: taken
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_PC_LOAD);

        fetch(8'h81, 1'b0);                      // JZ, zero=0: not taken
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_PC_COUNT);

        fetch(8'h3F, 1'b1);                      // SUB: carry<=0 zero<=1
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_MAR_IN | K_PC_COUNT);
        row(T6, K_NONE);
        row(T7, K_RAM_OUT | K_B_IN);
        row(T8, K_ALU_OUT | K_A_IN | K_FLAGS | K_ALU_SUB, 1'b0, 1'b1);
        row(T9, K_NONE);

        fetch(8'h82, 1'b0);                      // JZ, zero=1: taken
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_PC_LOAD);

        fetch(8'h70, 1'b0);                      // JC, carry=0: not taken
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_PC_COUNT);

        fetch(8'h6C, 1'b0);                      // JMP
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_PC_LOAD);

        fetch(8'h1E, 1'b1);                      // LDA
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_MAR_IN | K_PC_COUNT);
        row(T6, K_NONE);
        row(T7, K_RAM_OUT | K_A_IN);
        row(T8, K_NONE);
        row(T9, K_NONE);

        fetch(8'hE0, 1'b0);                      // OUT
        row(T3, K_A_OUT | K_OUT_IN);
        row(T4, K_NONE);
        row(T5, K_NONE);

        fetch(8'h00, 1'b0);                      // NOP
        row(T3, K_NONE);
        row(T4, K_NONE);
        row(T5, K_NONE);

        fetch(8'h4D, 1'b1);                      // STA
        row(T3, K_PC_OUT | K_MAR_IN);
        row(T4, K_NONE);
        row(T5, K_RAM_OUT | K_MAR_IN | K_PC_COUNT);
        row(T6, K_NONE);
        row(T7, K_A_OUT | K_RAM_IN);
        row(T8, K_NONE);
        row(T9, K_NONE);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].t, vecs[i].bus, vecs[i].c, vecs[i].z, s);
            check($sformatf("vec%0d strobes", i), {2'b00, s}, {2'b00, vecs[i].strb});
            check($sformatf("vec%0d ext", i), {15'd0, ctl.extended_fetch}, {15'd0, vecs[i].ext});
            check($sformatf("vec%0d operand", i), {12'd0, ctl.ir_operand}, {12'd0, vecs[i].opnd});
            $display("vec %0d t=%h bus=%h strobes=%h ext=%b operand=%h",
                     i, vecs[i].t, vecs[i].bus, s, ctl.extended_fetch, ctl.ir_operand);
        end

        // ---------------- non-one-hot t_state (IR = 0x4D) ----------------
        step("twohot 003", 10'h003, 8'h5A, K_NONE);
        check("twohot 003 operand", {12'd0, ctl.ir_operand}, 16'h000D);
        step("twohot 005", 10'h005, 8'hF0, K_NONE);
        check("twohot 005 operand", {12'd0, ctl.ir_operand}, 16'h000D);
        check("twohot 005 ext", {15'd0, ctl.extended_fetch}, 16'h0001);
        step("zero tstate", 10'h000, 8'h5A, K_NONE);
        check("zero tstate halted", {15'd0, ctl.halted}, 16'h0000);

        // ---------------- async clear in T7 of STA ----------------
        step("sta T0", T0, 8'hFF, K_PC_OUT | K_MAR_IN);
        step("sta T1", T1, 8'hFF, K_NONE);
        step("sta T2", T2, 8'h47, K_RAM_OUT | K_PC_COUNT);
        step("sta T3", T3, 8'hFF, K_PC_OUT | K_MAR_IN);
        step("sta T4", T4, 8'hFF, K_NONE);
        step("sta T5", T5, 8'hFF, K_RAM_OUT | K_MAR_IN | K_PC_COUNT);
        step("sta T6", T6, 8'hFF, K_NONE);
        @(negedge clk);
        ctl.t_state = T7;
        #1;
        check("sta T7 strobes", {2'b00, strobes()}, {2'b00, K_A_OUT | K_RAM_IN});
        #1;
        clear = 1'b1;
        #1;
        check("clear ram_in",  {15'd0, ctl.ram_in},         16'h0000);
        check("clear strobes", {2'b00, strobes()},          16'h0000);
        check("clear ext",     {15'd0, ctl.extended_fetch}, 16'h0000);
        check("clear operand", {12'd0, ctl.ir_operand},     16'h0000);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("after clear T7 strobes", {2'b00, strobes()}, 16'h0000);
        // zero was 1 before the clear; JZ must now fall through.
        step("jz T0", T0, 8'hFF, K_PC_OUT | K_MAR_IN);
        step("jz T1", T1, 8'hFF, K_NONE);
        step("jz T2", T2, 8'h80, K_RAM_OUT | K_PC_COUNT);
        step("jz T3", T3, 8'hFF, K_PC_OUT | K_MAR_IN);
        step("jz T4", T4, 8'hFF, K_NONE);
        step("jz T5 flags cleared", T5, 8'hFF, K_PC_COUNT);

        // ---------------- undefined opcode 0xB ----------------
        step("ill T0", T0, 8'hFF, K_PC_OUT | K_MAR_IN);
        step("ill T1", T1, 8'hFF, K_NONE);
        step("ill T2", T2, 8'hB7, K_RAM_OUT | K_PC_COUNT);
        check("ill ext", {15'd0, ctl.extended_fetch}, 16'h0000);
        step("ill T3", T3, 8'hFF, K_NONE);
`ifdef SEQ_ILLEGAL_TRAP_EN
        check("ill halted",      {15'd0, ctl.halted},      16'h0001);
        check("ill illegal_op",  {15'd0, ctl.illegal_op},  16'h0001);
        check("ill ring_enable", {15'd0, ctl.ring_enable}, 16'h0000);
        step("ill halted T0", T0, 8'hFF, K_NONE);
        pulse_clear();
        #1;
        check("ill cleared illegal_op", {15'd0, ctl.illegal_op}, 16'h0000);
        check("ill cleared halted",     {15'd0, ctl.halted},     16'h0000);
`else
        check("ill halted",      {15'd0, ctl.halted},      16'h0000);
        check("ill ring_enable", {15'd0, ctl.ring_enable}, 16'h0001);
        step("ill T4", T4, 8'hFF, K_NONE);
        step("ill T5", T5, 8'hFF, K_NONE);
`endif

        // ---------------- HLT ----------------
        step("hlt T0", T0, 8'hFF, K_PC_OUT | K_MAR_IN);
        step("hlt T1", T1, 8'hFF, K_NONE);
        step("hlt T2", T2, 8'hF0, K_RAM_OUT | K_PC_COUNT);
        @(negedge clk);
        ctl.t_state = T3;
        #1;
        check("hlt T3 halted before edge", {15'd0, ctl.halted}, 16'h0000);
        @(posedge clk);
        #1;
        check("hlt halted",      {15'd0, ctl.halted},      16'h0001);
        check("hlt ring_enable", {15'd0, ctl.ring_enable}, 16'h0000);
        step("hlt then T0", T0, 8'hFF, K_NONE);
        step("hlt then T2", T2, 8'h5A, K_NONE);
        check("hlt IR frozen", {12'd0, ctl.ir_operand}, 16'h0000);
        check("hlt sticky",    {15'd0, ctl.halted},     16'h0001);
        pulse_clear();
        #1;
        check("hlt cleared halted",      {15'd0, ctl.halted},      16'h0000);
        check("hlt cleared ring_enable", {15'd0, ctl.ring_enable}, 16'h0001);
        step("post clear T0", T0, 8'hFF, K_PC_OUT | K_MAR_IN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
